// File: rtl/decode_pkg.sv
// Shared constants and field helpers for the decode stage.
// Build with DECODE_SCOREBOARD_EN defined to enable the RAW-hazard scoreboard.
package decode_pkg;

  localparam int unsigned DEF_INSTRUCTION_WIDTH = 28;
  localparam int unsigned DEF_WIDTH_OPCODE      = 5;
  localparam int unsigned DEF_REGFILE_ADDR_BITS = 5;
  localparam int unsigned DEF_IMMEDIATE_WIDTH   = 8;
  localparam int unsigned DEF_DATA_WIDTH        = 32;
  localparam int unsigned DEF_NUM_INSTRUCTIONS  = 32;
  localparam int unsigned MASK_WIDTH            = 32;

  localparam int unsigned INSTR_NOP = 0;
  localparam int unsigned INSTR_ADD = 1;
  localparam int unsigned INSTR_LR  = 2;
  localparam int unsigned INSTR_SR  = 3;
  localparam int unsigned INSTR_LI  = 6;

  // Opcodes that write reg_dest (ADD, LR, LI) and that read it as accumulator/base (ADD, SR).
  localparam logic [MASK_WIDTH-1:0] DEF_WRITES_DEST_MASK = 32'h0000_0046;
  localparam logic [MASK_WIDTH-1:0] DEF_READS_DEST_MASK  = 32'h0000_000A;

  function automatic logic [31:0] field_extract(input logic [63:0] word,
                                                input int unsigned lsb,
                                                input int unsigned width);
    logic [63:0] shifted;
    logic [63:0] mask;
    shifted = word >> lsb;
    mask    = (64'd1 << width) - 64'd1;
    return 32'(shifted & mask);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bit per register with one set port, one clear port and two lookups.
// Register 0 is never marked pending; a same-cycle set and clear of one register leaves it set.
module regfile_scoreboard
  import decode_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_REGFILE_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_set,
  input  logic [ADDR_BITS-1:0] i_set_addr,
  input  logic                 i_clr,
  input  logic [ADDR_BITS-1:0] i_clr_addr,
  input  logic [ADDR_BITS-1:0] i_rd0_addr,
  output logic                 o_rd0_pending_c,
  input  logic [ADDR_BITS-1:0] i_rd1_addr,
  output logic                 o_rd1_pending_c
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_BITS;

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set && (i_set_addr != '0)) w_set_mask[i_set_addr] = 1'b1;
    if (i_clr)                       w_clr_mask[i_clr_addr] = 1'b1;
  end

  // Set applied after clear so a colliding issue keeps its pending bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

  assign o_rd0_pending_c = r_pending[i_rd0_addr];
  assign o_rd1_pending_c = r_pending[i_rd1_addr];

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute with valid/ready, flush and illegal detect.
// Define DECODE_SCOREBOARD_EN to add the RAW scoreboard stall; otherwise wb_* are ignored.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int unsigned WIDTH_OPCODE      = DEF_WIDTH_OPCODE,
  parameter int unsigned REGFILE_ADDR_BITS = DEF_REGFILE_ADDR_BITS,
  parameter int unsigned IMMEDIATE_WIDTH   = DEF_IMMEDIATE_WIDTH,
  parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int unsigned NUM_INSTRUCTIONS  = DEF_NUM_INSTRUCTIONS,
  parameter logic [MASK_WIDTH-1:0] WRITES_DEST_MASK = DEF_WRITES_DEST_MASK,
  parameter logic [MASK_WIDTH-1:0] READS_DEST_MASK  = DEF_READS_DEST_MASK
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instr,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH_OPCODE-1:0]      out_opcode,
  output logic [REGFILE_ADDR_BITS-1:0] out_reg_dest,
  output logic [REGFILE_ADDR_BITS-1:0] out_reg_source,
  output logic [DATA_WIDTH-1:0]        out_immediate,
  output logic [NUM_INSTRUCTIONS-1:0]  out_decoded,
  output logic                         out_illegal,
  input  logic                         flush,
  input  logic                         wb_valid,
  input  logic [REGFILE_ADDR_BITS-1:0] wb_addr
);

  localparam int unsigned OPCODE_LSB = INSTRUCTION_WIDTH - WIDTH_OPCODE;
  localparam int unsigned DEST_LSB   = OPCODE_LSB - REGFILE_ADDR_BITS;
  localparam int unsigned SRC_LSB    = DEST_LSB - REGFILE_ADDR_BITS;

  logic [WIDTH_OPCODE-1:0]      w_opcode;
  logic [REGFILE_ADDR_BITS-1:0] w_dest;
  logic [REGFILE_ADDR_BITS-1:0] w_src;
  logic [DATA_WIDTH-1:0]        w_imm;
  logic [NUM_INSTRUCTIONS-1:0]  w_decoded;
  logic                         w_illegal;
  logic                         w_hazard;
  logic                         w_accept;
  logic                         w_issue;

  assign w_opcode = WIDTH_OPCODE'(field_extract(64'(in_instr), OPCODE_LSB, WIDTH_OPCODE));
  assign w_dest   = REGFILE_ADDR_BITS'(field_extract(64'(in_instr), DEST_LSB, REGFILE_ADDR_BITS));
  assign w_src    = REGFILE_ADDR_BITS'(field_extract(64'(in_instr), SRC_LSB, REGFILE_ADDR_BITS));
  assign w_imm    = {{(DATA_WIDTH - IMMEDIATE_WIDTH){in_instr[IMMEDIATE_WIDTH-1]}},
                     in_instr[IMMEDIATE_WIDTH-1:0]};

  // An opcode outside the decoded range matches no bit, which is exactly the illegal case.
  always_comb begin
    w_decoded = '0;
    for (int unsigned k = 0; k < NUM_INSTRUCTIONS; k++) begin
      w_decoded[k] = (w_opcode == WIDTH_OPCODE'(k));
    end
  end

  assign w_illegal = ~|w_decoded;

`ifdef DECODE_SCOREBOARD_EN
  logic w_sb_set;
  logic w_src_pending;
  logic w_dest_pending;

  assign w_sb_set = w_issue & WRITES_DEST_MASK[out_opcode] & ~out_illegal;

  regfile_scoreboard #(
    .ADDR_BITS (REGFILE_ADDR_BITS)
  ) u_scoreboard (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_set           (w_sb_set),
    .i_set_addr      (out_reg_dest),
    .i_clr           (wb_valid),
    .i_clr_addr      (wb_addr),
    .i_rd0_addr      (w_src),
    .o_rd0_pending_c (w_src_pending),
    .i_rd1_addr      (w_dest),
    .o_rd1_pending_c (w_dest_pending)
  );

  assign w_hazard = ((w_src != '0) & w_src_pending) |
                    ((w_dest != '0) & w_dest_pending & READS_DEST_MASK[w_opcode]);
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_valid, wb_addr};
  assign w_hazard    = 1'b0;
`endif

  assign in_ready = (~out_valid | out_ready) & ~w_hazard & ~flush;
  assign w_accept = in_valid & in_ready;
  assign w_issue  = out_valid & out_ready;

  // Output register: load on accept, drop on issue or flush, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_opcode     <= '0;
      out_reg_dest   <= '0;
      out_reg_source <= '0;
      out_immediate  <= '0;
      out_decoded    <= '0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid      <= 1'b1;
      out_opcode     <= w_opcode;
      out_reg_dest   <= w_dest;
      out_reg_source <= w_src;
      out_immediate  <= w_imm;
      out_decoded    <= w_decoded;
      out_illegal    <= w_illegal;
    end else if (w_issue) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (NUM_INSTRUCTIONS=8) with a per-cycle reference model.
module tb_decode_stage;

  localparam int unsigned NI = 8;
`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  localparam logic [27:0] LI_R5    = 28'h3140014;
  localparam logic [27:0] LI_R0_M1 = 28'h30000FF;
  localparam logic [27:0] ADD_R8R5 = 28'h0A0A000;
  localparam logic [27:0] LI_R9    = 28'h3240001;
  localparam logic [27:0] LI_R10   = 28'h3280002;
  localparam logic [27:0] LI_R11   = 28'h32C0003;
  localparam logic [27:0] ILL_9    = 28'h4B0007F;
  localparam logic [27:0] ADD_R12  = 28'h0B00000;
  localparam logic [27:0] LI_R0    = 28'h3000005;
  localparam logic [27:0] ADD_R0R0 = 28'h0800000;
  localparam logic [27:0] LI_R13   = 28'h3340000;
  localparam logic [27:0] LI_R8    = 28'h3200000;
  localparam logic [27:0] ADD_R1R8 = 28'h0850000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [27:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode;
  logic [4:0]  out_reg_dest;
  logic [4:0]  out_reg_source;
  logic [31:0] out_immediate;
  logic [NI-1:0] out_decoded;
  logic        out_illegal;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_addr;

  int n_checks = 0;
  int n_errors = 0;

  decode_stage #(.NUM_INSTRUCTIONS(NI)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_instr       (in_instr),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_opcode     (out_opcode),
    .out_reg_dest   (out_reg_dest),
    .out_reg_source (out_reg_source),
    .out_immediate  (out_immediate),
    .out_decoded    (out_decoded),
    .out_illegal    (out_illegal),
    .flush          (flush),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the stage must be holding, from the word arithmetic alone.
  int unsigned m_valid, m_op, m_dst, m_src, m_imm, m_dec, m_ill;
  bit          pend [32];

  always @(negedge clk) begin
    int unsigned w, op, dst, src, imm;
    bit hz, exp_ready, issue;
    if (!rst_n) begin
      m_valid = 0; m_op = 0; m_dst = 0; m_src = 0; m_imm = 0; m_dec = 0; m_ill = 0;
      foreach (pend[r]) pend[r] = 1'b0;
    end
    check("m_out_valid", 64'(out_valid), 64'(m_valid));
    check("m_opcode", 64'(out_opcode), 64'(m_op));
    check("m_dest", 64'(out_reg_dest), 64'(m_dst));
    check("m_src", 64'(out_reg_source), 64'(m_src));
    check("m_imm", 64'(out_immediate), 64'(m_imm));
    check("m_decoded", 64'(out_decoded), 64'(m_dec));
    check("m_illegal", 64'(out_illegal), 64'(m_ill));

    w   = 32'(in_instr);
    op  = w / (1 << 23);
    dst = (w / (1 << 18)) % 32;
    src = (w / (1 << 13)) % 32;
    imm = w % 256;
    hz  = SB && (((src != 0) && pend[src]) ||
                 ((dst != 0) && pend[dst] && (op == 1 || op == 3)));
    exp_ready = ((m_valid == 0) || out_ready) && !hz && !flush;
    check("m_in_ready", 64'(in_ready), 64'(exp_ready));

    if (rst_n) begin
      issue = (m_valid != 0) && out_ready;
      if (SB) begin
        if (wb_valid && wb_addr != 0) pend[wb_addr] = 1'b0;
        if (issue && m_ill == 0 && m_dst != 0 && (m_op == 1 || m_op == 2 || m_op == 6))
          pend[m_dst] = 1'b1;
      end
      if (flush) m_valid = 0;
      else if (in_valid && exp_ready) begin
        m_valid = 1; m_op = op; m_dst = dst; m_src = src;
        m_imm   = (imm >= 128) ? (32'hFFFF_FF00 | imm) : imm;
        m_ill   = (op >= NI) ? 1 : 0;
        m_dec   = (op >= NI) ? 0 : (1 << op);
      end else if (issue) m_valid = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    flush = 1'b0; wb_valid = 1'b0; wb_addr = '0;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_decoded", 64'(out_decoded), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Field decode and sign extension
    in_valid = 1'b1; in_instr = LI_R5;
    tick();
    check("li_opcode", 64'(out_opcode), 64'd6);
    check("li_dest", 64'(out_reg_dest), 64'd5);
    check("li_src", 64'(out_reg_source), 64'd0);
    check("li_imm", 64'(out_immediate), 64'h14);
    check("li_decoded", 64'(out_decoded), 64'h40);
    in_instr = LI_R0_M1;
    tick();
    check("imm_sext", 64'(out_immediate), 64'hFFFF_FFFF);

    // RAW stall on R5 until writeback, no bypass
    in_instr = ADD_R8R5; #1;
    check("raw_stall", 64'(in_ready), 64'(!SB));
    tick();
    check("raw_stall_hold", 64'(in_ready), 64'(!SB));
    wb_valid = 1'b1; wb_addr = 5'd5; #1;
    check("raw_no_bypass", 64'(in_ready), 64'(!SB));
    tick();
    wb_valid = 1'b0; #1;
    check("raw_released", 64'(in_ready), 64'd1);
    tick();
    check("raw_add_op", 64'(out_opcode), 64'd1);
    check("raw_add_dest", 64'(out_reg_dest), 64'd8);

    // Backpressure holds outputs, then one issue per cycle
    in_instr = LI_R9;
    tick();
    out_ready = 1'b0; in_instr = LI_R10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_dest", 64'(out_reg_dest), 64'd9);
      check("bp_imm", 64'(out_immediate), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next", 64'(out_reg_dest), 64'd10);
    in_instr = LI_R11;
    tick();
    check("bp_next2", 64'(out_reg_dest), 64'd11);
    in_valid = 1'b0;
    tick();

    // Illegal opcode and R0 handling
    in_valid = 1'b1; in_instr = ILL_9;
    tick();
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_decoded", 64'(out_decoded), 64'd0);
    check("ill_opcode", 64'(out_opcode), 64'd9);
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_instr = ADD_R12; #1;
    check("ill_no_pending", 64'(in_ready), 64'd1);
    tick();
    in_instr = LI_R0;
    tick();
    in_instr = ADD_R0R0; #1;
    check("r0_no_stall", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    tick();

    // Flush drops the held word and the incoming one
    in_valid = 1'b1; in_instr = LI_R13; out_ready = 1'b0;
    tick();
    check("fl_pre_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; #1;
    check("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Issue of R8 collides with writeback of R8: set wins
    in_valid = 1'b1; in_instr = LI_R8; #1;
    check("col_accept", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd8;
    tick();
    wb_valid = 1'b0; in_valid = 1'b1; in_instr = ADD_R1R8; #1;
    check("col_set_wins", 64'(in_ready), 64'(!SB));

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0; #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_opcode", 64'(out_opcode), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1; #1;
    check("mr_released", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("mr_add_src", 64'(out_reg_source), 64'd8);
    in_valid = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage. Sits between fetch and execute.
- Splits the 2-operand, accumulator-mode instruction word into opcode, reg_dest, reg_source and immediate, and produces a one-hot decoded vector.
- Adds a valid/ready handshake, a flush input, illegal-opcode detection, immediate sign extension, and a register scoreboard that stalls on read-after-write hazards.

Parameters:
- INSTRUCTION_WIDTH, 28, instruction word width.
- WIDTH_OPCODE, 5, opcode field width (MSBs of the word).
- REGFILE_ADDR_BITS, 5, register index width; NUM_REGISTERS = 2**REGFILE_ADDR_BITS.
- IMMEDIATE_WIDTH, 8, immediate field width (LSBs of the word).
- DATA_WIDTH, 32, width of the sign-extended immediate.
- NUM_INSTRUCTIONS, 32, number of legal opcodes; width of the decoded vector.
- WRITES_DEST_MASK, 32'h0000_0046, bit k set means opcode k writes reg_dest (ADD=1, LR=2, LI=6).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_instr  in  INSTRUCTION_WIDTH  instruction word
- in_ready  out  1  stage accepts in_instr this cycle
- out_valid  out  1  decoded outputs valid
- out_ready  in  1  execute consumes outputs
- out_opcode  out  WIDTH_OPCODE  word[W-1 : W-WIDTH_OPCODE]
- out_reg_dest  out  REGFILE_ADDR_BITS  next REGFILE_ADDR_BITS bits below the opcode
- out_reg_source  out  REGFILE_ADDR_BITS  next REGFILE_ADDR_BITS bits below reg_dest
- out_immediate  out  DATA_WIDTH  word[IMMEDIATE_WIDTH-1:0], sign-extended
- out_decoded  out  NUM_INSTRUCTIONS  one-hot of opcode
- out_illegal  out  1  opcode >= NUM_INSTRUCTIONS
- flush  in  1  discard held and incoming instruction
- wb_valid  in  1  writeback retiring a register write
- wb_addr  in  REGFILE_ADDR_BITS  register being written back

Behaviour:
- Reset (asynchronous, any cycle, including mid-stall): out_valid=0; all out_* data=0; scoreboard all clear. in_ready follows its equation from the cleared state.
- Latency: accepted word appears on the outputs on the next clk edge (1 cycle).
- Acceptance: accept = in_valid & in_ready.
  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
  - On accept, register all fields and set out_valid=1.
  - On out_valid & out_ready with no accept, clear out_valid.
  - Outputs stay stable while out_valid & !out_ready.
- out_decoded: bit opcode set; all-zero when out_illegal=1. An illegal word still flows through with out_illegal=1.
- Scoreboard: pending[NUM_REGISTERS].
  - Issue (out_valid & out_ready) with WRITES_DEST_MASK[opcode], !illegal and reg_dest!=0 sets pending[reg_dest].
  - wb_valid clears pending[wb_addr].
  - If set and clear target the same register in the same cycle, set wins.
  - wb_addr=0 is ignored; pending[0] is never set.
- Hazard: combinational on in_instr.
  - hazard = (src!=0 & pending[src]) | (dst!=0 & pending[dst] & opcode reads dest).
  - Opcodes that read dest: ADD=1 and SR=3 (accumulator/base). LI and NOP do not.
  - No bypass: a clear becomes visible to hazard on the cycle after wb_valid.
  - The instruction held in the output register is not yet in the scoreboard; execute is responsible for that ordering.
- Flush: next edge forces out_valid=0, drops any incoming word, and holds in_ready=0 that cycle. Scoreboard is unaffected, because in-flight writers still retire.

Optional Feature:
- Macro DECODE_SCOREBOARD_EN.
- Defined: scoreboard and hazard stall as above.
- Undefined: no pending state, hazard tied to 0, wb_valid/wb_addr ignored (ports remain).

Decomposition:
- Shared package decode_pkg holds:
  - width constants;
  - opcode localparams INSTR_NOP=0, INSTR_ADD=1, INSTR_LR=2, INSTR_SR=3, INSTR_LI=6;
  - WRITES_DEST_MASK and reads-dest mask defaults;
  - field-extract functions.
- One sub-module, regfile_scoreboard: pending bits, set/clear ports and two hazard lookup ports.

Test Plan:
- Reset: assert rst_n=0 mid-stall -> out_valid=0, outputs 0, pending cleared, in_ready=1 after release.
- Field decode: in 0x3140014 (li R5,20) -> opcode 6, dest 5, src 0, immediate 0x00000014, decoded=0x40. In 0x30000FF -> immediate 0xFFFFFFFF.
- RAW stall: issue li R5, then add R8,R5 (0x0A0A000) -> in_ready=0 until a wb_valid/wb_addr=5 pulse; add accepted the following cycle.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Raise out_ready -> one issue per cycle, no drop or duplicate.
- Illegal plus R0: with NUM_INSTRUCTIONS=8, opcode 9 -> out_illegal=1, decoded=0, no pending set. li R0 issued -> a following add R0,R0 does not stall.
- Flush and set/clear collision: flush with out_valid=1 -> out_valid=0 next cycle. Issue li R8 in the same cycle as wb_addr=8 -> pending[8]=1.
